// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-entry holding register.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around each bit centre.
module uart_rx #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 4000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int WAIT_STATES = CLK_FREQ / BAUD_RATE;
  localparam int CW =
    (WAIT_STATES > 4) ? $clog2(WAIT_STATES) : 2;
  localparam logic [CW-1:0] HALF =
    CW'(WAIT_STATES / 2 - 1);
  localparam logic [CW-1:0] FULL =
    CW'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          rx_q, rx_s;
  logic          bit_s;
  logic          deliver;
  logic          ferr_n;

  // two-flop synchronizer, idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_q <= rx;
      rx_s <= rx_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic s2, s1;

  // capture the two samples preceding the centre
  always_ff @(posedge clk) begin
    if (rst) begin
      s2 <= 1'b1;
      s1 <= 1'b1;
    end else begin
      if (count == CW'(2)) s2 <= rx_s;
      if (count == CW'(1)) s1 <= rx_s;
    end
  end

  assign bit_s = (s2 & s1) | (s2 & rx_s) | (s1 & rx_s);
`else
  assign bit_s = rx_s;
`endif

  // FSM state, bit counter and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      idx   <= idx_n;
      shift <= shift_n;
    end
  end

  // next-state, bit sampling and delivery decode
  always_comb begin
    state_n = state;
    count_n = count;
    idx_n   = idx;
    shift_n = shift;
    deliver = 1'b0;
    ferr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          count_n = HALF;
        end
      end
      START: begin
        if (count == '0) begin
          if (!bit_s) begin
            state_n = DATA;
            count_n = FULL;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          count_n = count - 1'b1;
        end
      end
      DATA: begin
        if (count == '0) begin
          shift_n[idx] = bit_s;
          count_n      = FULL;
          if (idx == 3'd7) state_n = STOP;
          else idx_n = idx + 3'd1;
        end else begin
          count_n = count - 1'b1;
        end
      end
      STOP: begin
        if (count == '0) begin
          if (bit_s) begin
            deliver = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end else begin
          count_n = count - 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // holding register, handshake and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_n;
      if (deliver) begin
        if (!valid || ready) begin
          data  <= shift;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
